// File: rtl/ip_hdr_assembler_arbiter.sv
// Round-robin arbiter sharing one IP header assembler between NUM_SRCS protocol engines.
// Optional per-source grant counters are enabled by defining IP_HDR_ARB_STATS_EN.

`ifdef IP_HDR_ARB_STATS_EN
module ip_hdr_arb_grant_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule
`endif

module ip_hdr_assembler_arbiter #(
  parameter int NUM_SRCS        = 2,
  parameter int SRC_ID_W        = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1,
  parameter int IP_ADDR_W       = 32,
  parameter int TOT_LEN_W       = 16,
  parameter int PROTOCOL_W      = 8,
  parameter int PKT_TIMESTAMP_W = 64,
  parameter int IP_HDR_W        = 160
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_SRCS-1:0]                 src_req_val,
  input  logic [NUM_SRCS*IP_ADDR_W-1:0]       src_source_ip_addr,
  input  logic [NUM_SRCS*IP_ADDR_W-1:0]       src_dest_ip_addr,
  input  logic [NUM_SRCS*TOT_LEN_W-1:0]       src_data_payload_len,
  input  logic [NUM_SRCS*PROTOCOL_W-1:0]      src_protocol,
  input  logic [NUM_SRCS*PKT_TIMESTAMP_W-1:0] src_timestamp,
  output logic [NUM_SRCS-1:0]                 src_req_rdy,
  output logic [NUM_SRCS-1:0]                 src_hdr_val,
  input  logic [NUM_SRCS-1:0]                 src_hdr_rdy,
  output logic [IP_HDR_W-1:0]                 src_hdr,
  output logic [PKT_TIMESTAMP_W-1:0]          src_hdr_timestamp,
  output logic                                asm_req_val,
  output logic [IP_ADDR_W-1:0]                asm_source_ip_addr,
  output logic [IP_ADDR_W-1:0]                asm_dest_ip_addr,
  output logic [TOT_LEN_W-1:0]                asm_data_payload_len,
  output logic [PROTOCOL_W-1:0]               asm_protocol,
  output logic [PKT_TIMESTAMP_W-1:0]          asm_timestamp,
  input  logic                                asm_req_rdy,
  input  logic                                asm_hdr_val,
  output logic                                asm_hdr_rdy,
  input  logic [IP_HDR_W-1:0]                 asm_hdr,
  input  logic [PKT_TIMESTAMP_W-1:0]          asm_hdr_timestamp,
  output logic [NUM_SRCS*16-1:0]              grant_cnt
);

  typedef struct packed {
    logic [IP_ADDR_W-1:0]       sip;
    logic [IP_ADDR_W-1:0]       dip;
    logic [TOT_LEN_W-1:0]       len;
    logic [PROTOCOL_W-1:0]      proto;
    logic [PKT_TIMESTAMP_W-1:0] ts;
  } req_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_HDR = 2'd2
  } state_t;

  req_t [NUM_SRCS-1:0] src_req;

  for (genvar i = 0; i < NUM_SRCS; i++) begin : g_unpack
    assign src_req[i].sip   = src_source_ip_addr[i*IP_ADDR_W +: IP_ADDR_W];
    assign src_req[i].dip   = src_dest_ip_addr[i*IP_ADDR_W +: IP_ADDR_W];
    assign src_req[i].len   = src_data_payload_len[i*TOT_LEN_W +: TOT_LEN_W];
    assign src_req[i].proto = src_protocol[i*PROTOCOL_W +: PROTOCOL_W];
    assign src_req[i].ts    = src_timestamp[i*PKT_TIMESTAMP_W +: PKT_TIMESTAMP_W];
  end

  state_t              state_q, state_d;
  logic [SRC_ID_W-1:0] rr_q, rr_d;
  logic [SRC_ID_W-1:0] own_q, own_d;
  req_t                fld_q, fld_d;

  logic                win_found;
  logic [SRC_ID_W-1:0] win_id;
  logic                req_hs;

  // Rotating priority scan starting at the round-robin pointer.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_SRCS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_SRCS) idx = idx - NUM_SRCS;
      if (!win_found && src_req_val[idx]) begin
        win_found = 1'b1;
        win_id    = SRC_ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    rr_d              = rr_q;
    own_d             = own_q;
    fld_d             = fld_q;
    req_hs            = 1'b0;
    src_req_rdy       = '0;
    src_hdr_val       = '0;
    asm_req_val       = 1'b0;
    asm_hdr_rdy       = 1'b0;
    src_hdr           = '0;
    src_hdr_timestamp = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          src_req_rdy[win_id] = 1'b1;
          req_hs              = 1'b1;
          fld_d               = src_req[win_id];
          own_d               = win_id;
          state_d             = ISSUE;
        end
      end
      ISSUE: begin
        asm_req_val = asm_req_rdy;
        if (asm_req_rdy) state_d = WAIT_HDR;
      end
      WAIT_HDR: begin
        src_hdr_val[own_q] = asm_hdr_val;
        asm_hdr_rdy        = src_hdr_rdy[own_q];
        src_hdr            = asm_hdr;
        src_hdr_timestamp  = asm_hdr_timestamp;
        if (asm_hdr_val && src_hdr_rdy[own_q]) begin
          // Pointer moves past the owner only once its header is delivered.
          rr_d    = (own_q == SRC_ID_W'(NUM_SRCS-1)) ? '0 : SRC_ID_W'(own_q + 1'b1);
          state_d = IDLE;
        end
      end
      default: begin
        state_d           = state_t'('x);
        rr_d              = 'x;
        own_d             = 'x;
        fld_d             = 'x;
        req_hs            = 1'bx;
        src_req_rdy       = 'x;
        src_hdr_val       = 'x;
        asm_req_val       = 1'bx;
        asm_hdr_rdy       = 1'bx;
        src_hdr           = 'x;
        src_hdr_timestamp = 'x;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      own_q   <= '0;
      fld_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      fld_q   <= fld_d;
    end
  end

  assign asm_source_ip_addr   = fld_q.sip;
  assign asm_dest_ip_addr     = fld_q.dip;
  assign asm_data_payload_len = fld_q.len;
  assign asm_protocol         = fld_q.proto;
  assign asm_timestamp        = fld_q.ts;

`ifdef IP_HDR_ARB_STATS_EN
  for (genvar i = 0; i < NUM_SRCS; i++) begin : g_stats
    ip_hdr_arb_grant_ctr u_ctr (
      .clk (clk),
      .rst (rst),
      .inc (req_hs && (win_id == SRC_ID_W'(i))),
      .cnt (grant_cnt[16*i +: 16])
    );
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_ip_hdr_assembler_arbiter.sv
// Directed, table-driven bench for ip_hdr_assembler_arbiter with NUM_SRCS=2.
module tb_ip_hdr_assembler_arbiter;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  src_req_val = '0;
  logic [N-1:0]  src_hdr_rdy = '0;
  logic          asm_req_rdy = 1'b0;
  logic          asm_hdr_val = 1'b0;
  logic [159:0]  asm_hdr = '0;
  logic [63:0]   asm_hdr_timestamp = '0;

  logic [N-1:0]  src_req_rdy, src_hdr_val;
  logic [159:0]  src_hdr;
  logic [63:0]   src_hdr_timestamp;
  logic          asm_req_val, asm_hdr_rdy;
  logic [31:0]   asm_source_ip_addr, asm_dest_ip_addr;
  logic [15:0]   asm_data_payload_len;
  logic [7:0]    asm_protocol;
  logic [63:0]   asm_timestamp;
  logic [N*16-1:0] grant_cnt;

  logic [31:0] sip [N] = '{32'h0A000001, 32'hC0A80001};
  logic [31:0] dip [N] = '{32'h0A000002, 32'hC0A80002};
  logic [15:0] len [N] = '{16'd100, 16'd200};
  logic [7:0]  pro [N] = '{8'd6, 8'd17};
  logic [63:0] tsv [N] = '{64'h1111, 64'h2222};

  ip_hdr_assembler_arbiter #(.NUM_SRCS(N)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .src_req_val          (src_req_val),
    .src_source_ip_addr   ({sip[1], sip[0]}),
    .src_dest_ip_addr     ({dip[1], dip[0]}),
    .src_data_payload_len ({len[1], len[0]}),
    .src_protocol         ({pro[1], pro[0]}),
    .src_timestamp        ({tsv[1], tsv[0]}),
    .src_req_rdy          (src_req_rdy),
    .src_hdr_val          (src_hdr_val),
    .src_hdr_rdy          (src_hdr_rdy),
    .src_hdr              (src_hdr),
    .src_hdr_timestamp    (src_hdr_timestamp),
    .asm_req_val          (asm_req_val),
    .asm_source_ip_addr   (asm_source_ip_addr),
    .asm_dest_ip_addr     (asm_dest_ip_addr),
    .asm_data_payload_len (asm_data_payload_len),
    .asm_protocol         (asm_protocol),
    .asm_timestamp        (asm_timestamp),
    .asm_req_rdy          (asm_req_rdy),
    .asm_hdr_val          (asm_hdr_val),
    .asm_hdr_rdy          (asm_hdr_rdy),
    .asm_hdr              (asm_hdr),
    .asm_hdr_timestamp    (asm_hdr_timestamp),
    .grant_cnt            (grant_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rv, hr;
    logic       arr, ahv;
    logic [1:0] e_rr, e_hv;
    logic       e_arv, e_ahr, e_pass;
    int         e_own;
  } vec_t;

  vec_t vecs [29];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int row, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] rv, hr, input logic arr, ahv,
                              input logic [1:0] e_rr, e_hv, input logic e_arv, e_ahr, e_pass,
                              input int e_own);
    vec_t v;
    v.rv = rv; v.hr = hr; v.arr = arr; v.ahv = ahv;
    v.e_rr = e_rr; v.e_hv = e_hv; v.e_arv = e_arv; v.e_ahr = e_ahr; v.e_pass = e_pass;
    v.e_own = e_own;
    return v;
  endfunction

  task automatic chk_zero_outputs(input int row);
    chk("rst_req_rdy", row, 160'(src_req_rdy), 160'd0);
    chk("rst_hdr_val", row, 160'(src_hdr_val), 160'd0);
    chk("rst_asm_req_val", row, 160'(asm_req_val), 160'd0);
    chk("rst_asm_hdr_rdy", row, 160'(asm_hdr_rdy), 160'd0);
    chk("rst_src_hdr", row, src_hdr, 160'd0);
    chk("rst_src_hdr_ts", row, 160'(src_hdr_timestamp), 160'd0);
    chk("rst_asm_sip", row, 160'(asm_source_ip_addr), 160'd0);
    chk("rst_asm_ts", row, 160'(asm_timestamp), 160'd0);
  endtask

  // One complete request/issue/header transaction; reports which source was granted.
  task automatic run_txn(input logic [1:0] rv, input int exp_who, input int row);
    int who;
    @(negedge clk);
    src_req_val = rv; asm_req_rdy = 1'b0; asm_hdr_val = 1'b0; src_hdr_rdy = '0;
    #2;
    who = (src_req_rdy == 2'b01) ? 0 : (src_req_rdy == 2'b10) ? 1 : -1;
    chk("rr_winner", row, 160'(who), 160'(exp_who));
    @(negedge clk);
    asm_req_rdy = 1'b1;
    #2;
    chk("txn_asm_req_val", row, 160'(asm_req_val), 160'd1);
    if (exp_who >= 0) chk("txn_asm_sip", row, 160'(asm_source_ip_addr), 160'(sip[exp_who]));
    @(negedge clk);
    asm_req_rdy = 1'b0; asm_hdr_val = 1'b1; src_hdr_rdy = 2'b11;
    #2;
    chk("txn_hdr_val", row, 160'(src_hdr_val), (exp_who >= 0) ? 160'(2'b01 << exp_who) : 160'd0);
    @(negedge clk);
    asm_hdr_val = 1'b0; src_hdr_rdy = '0; src_req_val = '0;
  endtask

  initial begin
    vecs[0]  = mk(2'b01, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0);
    vecs[1]  = mk(2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 1, 0, 0, 0);
    vecs[2]  = mk(2'b00, 2'b01, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0);
    vecs[3]  = mk(2'b00, 2'b01, 0, 1, 2'b00, 2'b01, 0, 1, 1, 0);
    vecs[4]  = mk(2'b11, 2'b00, 0, 0, 2'b10, 2'b00, 0, 0, 0, 1);
    vecs[5]  = mk(2'b11, 2'b00, 1, 0, 2'b00, 2'b00, 1, 0, 0, 1);
    vecs[6]  = mk(2'b11, 2'b10, 0, 1, 2'b00, 2'b10, 0, 1, 1, 1);
    vecs[7]  = mk(2'b11, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0);
    vecs[8]  = mk(2'b11, 2'b00, 1, 0, 2'b00, 2'b00, 1, 0, 0, 0);
    vecs[9]  = mk(2'b11, 2'b01, 0, 1, 2'b00, 2'b01, 0, 1, 1, 0);
    vecs[10] = mk(2'b11, 2'b00, 0, 0, 2'b10, 2'b00, 0, 0, 0, 1);
    vecs[11] = mk(2'b11, 2'b00, 1, 0, 2'b00, 2'b00, 1, 0, 0, 1);
    vecs[12] = mk(2'b11, 2'b01, 0, 1, 2'b00, 2'b10, 0, 0, 1, 1);
    vecs[13] = mk(2'b11, 2'b10, 0, 1, 2'b00, 2'b10, 0, 1, 1, 1);
    vecs[14] = mk(2'b11, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0);
    vecs[15] = mk(2'b11, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[16] = mk(2'b11, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[17] = mk(2'b11, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[18] = mk(2'b11, 2'b00, 1, 0, 2'b00, 2'b00, 1, 0, 0, 0);
    for (int i = 19; i < 24; i++)
      vecs[i] = mk(2'b11, 2'b00, 0, 1, 2'b00, 2'b01, 0, 0, 1, 0);
    vecs[24] = mk(2'b11, 2'b01, 0, 1, 2'b00, 2'b01, 0, 1, 1, 0);
    vecs[25] = mk(2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[26] = mk(2'b01, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0);
    vecs[27] = mk(2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 1, 0, 0, 0);
    vecs[28] = mk(2'b00, 2'b01, 0, 1, 2'b00, 2'b01, 0, 1, 1, 0);

    #3;
    chk_zero_outputs(-1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      src_req_val       = vecs[i].rv;
      src_hdr_rdy       = vecs[i].hr;
      asm_req_rdy       = vecs[i].arr;
      asm_hdr_val       = vecs[i].ahv;
      asm_hdr           = {5{32'hA5000000 + 32'(i)}};
      asm_hdr_timestamp = 64'hBEEF0000 + 64'(i);
      #2;
      chk("src_req_rdy", i, 160'(src_req_rdy), 160'(vecs[i].e_rr));
      chk("src_hdr_val", i, 160'(src_hdr_val), 160'(vecs[i].e_hv));
      chk("asm_req_val", i, 160'(asm_req_val), 160'(vecs[i].e_arv));
      chk("asm_hdr_rdy", i, 160'(asm_hdr_rdy), 160'(vecs[i].e_ahr));
      chk("src_hdr", i, src_hdr, vecs[i].e_pass ? asm_hdr : 160'd0);
      chk("src_hdr_ts", i, 160'(src_hdr_timestamp),
          vecs[i].e_pass ? 160'(asm_hdr_timestamp) : 160'd0);
      if (vecs[i].e_arv) begin
        chk("asm_sip", i, 160'(asm_source_ip_addr), 160'(sip[vecs[i].e_own]));
        chk("asm_dip", i, 160'(asm_dest_ip_addr), 160'(dip[vecs[i].e_own]));
        chk("asm_len", i, 160'(asm_data_payload_len), 160'(len[vecs[i].e_own]));
        chk("asm_proto", i, 160'(asm_protocol), 160'(pro[vecs[i].e_own]));
        chk("asm_ts", i, 160'(asm_timestamp), 160'(tsv[vecs[i].e_own]));
      end
    end

    // Reset asserted while source 1 waits on its header.
    @(negedge clk);
    src_req_val = 2'b10; src_hdr_rdy = '0; asm_req_rdy = 1'b0; asm_hdr_val = 1'b0;
    @(negedge clk);
    src_req_val = 2'b00; asm_req_rdy = 1'b1;
    @(negedge clk);
    asm_req_rdy = 1'b0; asm_hdr_val = 1'b1;
    #2;
    chk("pre_rst_hdr_val", 100, 160'(src_hdr_val), 160'(2'b10));
    rst = 1'b1;
    #1;
    chk_zero_outputs(100);
    @(negedge clk);
    rst = 1'b0; asm_hdr_val = 1'b0;
    #2;
    chk("post_rst_hdr_val", 101, 160'(src_hdr_val), 160'd0);

    run_txn(2'b11, 0, 200);
    run_txn(2'b11, 1, 201);
    run_txn(2'b11, 0, 202);
    run_txn(2'b11, 1, 203);
    run_txn(2'b11, 0, 204);

    #1;
`ifdef IP_HDR_ARB_STATS_EN
    chk("grant_cnt", 300, 160'(grant_cnt), 160'({16'd2, 16'd3}));
`else
    chk("grant_cnt", 300, 160'(grant_cnt), 160'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ip_hdr_assembler_arbiter.md
Name: ip_hdr_assembler_arbiter

Overview:
- Shares one IP header assembler between NUM_SRCS requesters (e.g. TCP TX engine, UDP TX engine, ICMP responder).
- Round-robin grants one header request at a time and forwards the winner's fields to the assembler.
- Tracks the owning source and routes the finished header and timestamp back to that source only.
- Sits in the TX frontend, between the protocol engines and the assembler.

Parameters:
- NUM_SRCS, 2, number of requesters (2..8).
- SRC_ID_W, $clog2(NUM_SRCS) (min 1), width of the owner and round-robin pointer registers.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- src_req_val  in  NUM_SRCS  per-source header request valid.
- src_source_ip_addr  in  NUM_SRCS*IP_ADDR_W  packed, source i at slice i.
- src_dest_ip_addr  in  NUM_SRCS*IP_ADDR_W  packed.
- src_data_payload_len  in  NUM_SRCS*TOT_LEN_W  packed.
- src_protocol  in  NUM_SRCS*PROTOCOL_W  packed.
- src_timestamp  in  NUM_SRCS*PKT_TIMESTAMP_W  packed.
- src_req_rdy  out  NUM_SRCS  per-source accept.
- src_hdr_val  out  NUM_SRCS  finished header valid, one-hot to owner.
- src_hdr_rdy  in  NUM_SRCS  per-source header ready.
- src_hdr  out  IP_HDR_W  ip_pkt_hdr, broadcast to all sources.
- src_hdr_timestamp  out  PKT_TIMESTAMP_W  broadcast.
- asm_req_val  out  1  to assembler ip_hdr_req_val.
- asm_source_ip_addr, asm_dest_ip_addr, asm_data_payload_len, asm_protocol, asm_timestamp  out  field widths  registered winner fields.
- asm_req_rdy  in  1  from assembler.
- asm_hdr_val  in  1  from assembler.
- asm_hdr_rdy  out  1  to assembler.
- asm_hdr  in  IP_HDR_W  from assembler.
- asm_hdr_timestamp  in  PKT_TIMESTAMP_W  from assembler.
- grant_cnt  out  NUM_SRCS*16  per-source grant counters (optional feature).

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; rr_ptr = 0; owner = 0; field registers = 0.
  - All outputs are 0: src_req_rdy, src_hdr_val, asm_req_val, asm_hdr_rdy and all data outputs.
- States: IDLE, ISSUE, WAIT_HDR. At most one header is in flight.
- IDLE:
  - Winner = first i with src_req_val[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_SRCS.
  - src_req_rdy is one-hot on the winner; all zero if no requester is valid.
  - On handshake: latch the winner's five fields and owner=winner, then go to ISSUE.
  - Losers see rdy=0 and must hold val and data stable.
- ISSUE:
  - Drive asm_* fields from registers.
  - asm_req_val = asm_req_rdy, so val is only raised while the assembler is ready.
  - When asm_req_rdy=1, go to WAIT_HDR. All src_req_rdy = 0.
- WAIT_HDR:
  - src_hdr_val[owner] = asm_hdr_val; other bits 0.
  - asm_hdr_rdy = src_hdr_rdy[owner].
  - src_hdr and src_hdr_timestamp pass through combinationally from asm_hdr and asm_hdr_timestamp.
  - On asm_hdr_val & asm_hdr_rdy: rr_ptr = owner+1 (wraps to 0 after NUM_SRCS-1), go to IDLE.
- Latency:
  - Source accept at cycle N; earliest asm_req_val at N+1.
  - Earliest next source accept is the cycle after the header handshake.
- Boundary conditions:
  - rr_ptr advances only on header completion, never on a bare grant.
  - src_hdr_rdy of non-owners is ignored.
  - asm_hdr_val arriving outside WAIT_HDR is not acknowledged (asm_hdr_rdy=0).
  - A source re-requesting in the cycle after its own completion loses to any other valid source.
- Reset mid-operation:
  - Immediate return to IDLE; the in-flight request is dropped with no src_hdr_val pulse.
  - The assembler shares rst and drops its in-flight request too.
- Unreachable state: all outputs X, next state X.

Optional Feature:
- Macro: IP_HDR_ARB_STATS_EN.
- Defined:
  - One 16-bit counter per source, incremented on each src_req handshake.
  - Counters saturate at 16'hFFFF and are cleared by rst.
  - Driven on grant_cnt, source i at bits [16*i+:16].
- Undefined:
  - No counter logic; grant_cnt tied to 0.

Test Plan:
- Single source 0: val with src 10.0.0.1, dst 10.0.0.2, len 100, proto 6 → asm_req_val at cycle+1 with those fields; src_hdr_val[0] when the assembler responds; src_hdr_val[1] stays 0.
- Sources 0 and 1 request continuously (NUM_SRCS=2) → grants alternate 0,1,0,1 over 4 headers; each header routed to the correct owner.
- Owner holds src_hdr_rdy=0 for 5 cycles → asm_hdr_rdy=0, header and val stable for 5 cycles; no new src_req_rdy until the handshake.
- asm_req_rdy held 0 for 3 cycles in ISSUE → asm_req_val=0 for those cycles, then 1 for exactly one cycle.
- rst pulsed during WAIT_HDR → outputs 0 asynchronously; after release, a fresh request is granted starting at source 0.
- With IP_HDR_ARB_STATS_EN, 3 grants to src0 and 2 to src1 → grant_cnt = {16'd2, 16'd3}; without the macro, grant_cnt = 0.
